uart_mem_loader: RTL

Downstream consumer of the UART receiver's byte stream. It frames incoming bytes as a load packet and writes the payload bytes sequentially into processor memory from address 0. A packet is a 2-byte big-endian length, then LEN payload bytes, then a 1-byte XOR checksum. It lets the host download a program or data image before the processor is released from hold.

---
 rtl/uart_mem_loader.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/uart_mem_loader.sv
// Frames a UART byte stream as a length/payload/checksum load packet and
// writes the payload sequentially into memory starting at address 0.
module uart_mem_loader #(
    parameter int AW          = 10,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          rx_done_tick,
    input  logic [7:0]    rx_data,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    err_code
);

    // state  | meaning
    // IDLE   | waiting for start; received bytes are dropped
    // LEN_HI | waiting for length high byte
    // LEN_LO | waiting for length low byte; length is range-checked here
    // DATA   | writing payload bytes to memory
    // CSUM   | waiting for the XOR checksum byte
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA, CSUM} state_t;

    localparam int          TW      = ($clog2(TIMEOUT_CYC) > 21) ? $clog2(TIMEOUT_CYC) : 21;
    localparam logic [16:0] MAX_LEN = 17'd1 << AW;
    localparam logic [TW-1:0] TC_LAST = TW'(TIMEOUT_CYC - 1);

    state_t          state, state_n;
    logic [7:0]      len_hi;
    logic [15:0]     remaining;
    logic [AW-1:0]   ptr;
    logic [7:0]      csum;
    logic [TW-1:0]   timer;
    logic [15:0]     len_full;
    logic            timeout;
    logic            wr_n, done_n, err_set;
    logic [1:0]      code_n;

    assign len_full = {len_hi, rx_data};
    // A byte arriving on the terminal cycle wins over the timeout.
    assign timeout  = (state != IDLE) && !rx_done_tick && (timer == TC_LAST);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (state == IDLE) begin
            if (start) state_n = LEN_HI;
        end else if (timeout) begin
            state_n = IDLE;
        end else if (rx_done_tick) begin
            case (state)
                LEN_HI: state_n = LEN_LO;
                LEN_LO: begin
                    if ({1'b0, len_full} > MAX_LEN) state_n = IDLE;
                    else if (len_full == 16'd0)     state_n = CSUM;
                    else                            state_n = DATA;
                end
                DATA:    if (remaining == 16'd1) state_n = CSUM;
                CSUM:    state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        wr_n    = 1'b0;
        done_n  = 1'b0;
        err_set = 1'b0;
        code_n  = 2'd0;
        if (timeout) begin
            err_set = 1'b1;
            code_n  = 2'd3;
        end else if (rx_done_tick) begin
            case (state)
                LEN_LO: if ({1'b0, len_full} > MAX_LEN) begin
                    err_set = 1'b1;
                    code_n  = 2'd2;
                end
                DATA: wr_n = 1'b1;
                CSUM: if (rx_data == csum) begin
                    done_n = 1'b1;
                end else begin
                    err_set = 1'b1;
                    code_n  = 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 8'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= 2'd0;
            len_hi    <= 8'd0;
            remaining <= 16'd0;
            ptr       <= '0;
            csum      <= 8'd0;
            timer     <= '0;
        end else begin
            mem_we <= wr_n;
            done   <= done_n;
            busy   <= (state_n != IDLE);

            if (err_set) begin
                err      <= 1'b1;
                err_code <= code_n;
            end else if (state == IDLE && start) begin
                err      <= 1'b0;
                err_code <= 2'd0;
            end

            if (state == IDLE) begin
                timer <= '0;
                if (start) begin
                    csum     <= 8'd0;
                    ptr      <= '0;
                    mem_addr <= '0;
                end
            end else if (rx_done_tick || timeout) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end

            if (rx_done_tick) begin
                case (state)
                    LEN_HI: len_hi    <= rx_data;
                    LEN_LO: remaining <= len_full;
                    DATA: begin
                        mem_addr  <= ptr;
                        mem_wdata <= rx_data;
                        ptr       <= ptr + 1'b1;
                        csum      <= csum ^ rx_data;
                        remaining <= remaining - 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
